// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI master controller.
// Header bit positions are given in transmission order (bit 0 goes out first).
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StHdr,
    StData,
    StGap,
    StEnd
  } state_e;

  localparam int unsigned HDR_BITS  = 8;
  localparam int unsigned DATA_BITS = 8;

  localparam int unsigned HDR_WR_POS  = 0;
  localparam int unsigned HDR_EXT_POS = 1;
  localparam int unsigned HDR_RSV_POS = 4;
  localparam int unsigned HDR_REG_POS = 5;

  // Packs the header so that shifting out LSB first yields WR, ext[0..2], 0, reg[0..2].
  function automatic logic [HDR_BITS-1:0] build_hdr(input logic       wr,
                                                    input logic [2:0] ext,
                                                    input logic [2:0] rg);
    logic [HDR_BITS-1:0] h;
    h                    = '0;
    h[HDR_WR_POS]        = wr;
    h[HDR_EXT_POS+:3]    = ext;
    h[HDR_RSV_POS]       = 1'b0;
    h[HDR_REG_POS+:3]    = rg;
    return h;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: CLK_DIV clk cycles per sclk half-period, low half first.
// fall_tick marks the first clk of a bit, sample_tick the last clk of its high half.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic fall_tick,
  output logic sample_tick
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;

  // Half-period counter; stopping forces the next bit to start with a fresh low half.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == DivLast) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign sclk        = phase_q;
  assign fall_tick   = run & ~phase_q & (cnt_q == 8'd0);
  assign sample_tick = run & phase_q & (cnt_q == DivLast);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master for the slave register banks: PRE sync pulse, 8-bit header, data bytes.
// Build option SPI_MASTER_CTRL_BURST_EN: honour cmd_len and emit GAP bits between bytes;
// otherwise every command is exactly one data byte.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [2:0] cmd_ext,
  input  logic [2:0] cmd_reg,
  input  logic [2:0] cmd_len,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       rsp_err,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso,
  input  logic       miso_oe
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic       wr_q, wr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rx_next;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] end_cnt_q, end_cnt_d;
  logic       mosi_q, mosi_d;
  logic       rd_valid_q, rd_valid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       run, fall_tick, sample_tick;

`ifdef SPI_MASTER_CTRL_BURST_EN
  logic [2:0] len_q, len_d;
  logic [2:0] byte_cnt_q, byte_cnt_d;
`else
  logic unused_cmd_len;
  assign unused_cmd_len = ^cmd_len;
`endif

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .sclk       (sclk),
    .fall_tick  (fall_tick),
    .sample_tick(sample_tick)
  );

  // Writes return the old value MSB first; reads arrive LSB first.
  assign rx_next = wr_q ? {rx_q[6:0], miso} : {miso, rx_q[7:1]};

  // Frame sequencer: next state, shift registers and strobes.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    end_cnt_d  = '0;
    mosi_d     = mosi_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    wr_ready   = 1'b0;
`ifdef SPI_MASTER_CTRL_BURST_EN
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d   = StPre;
          wr_d      = cmd_wr;
          tx_d      = build_hdr(cmd_wr, cmd_ext, cmd_reg);
          bit_cnt_d = '0;
          mosi_d    = 1'b0;
          err_d     = 1'b0;
`ifdef SPI_MASTER_CTRL_BURST_EN
          len_d      = cmd_len;
          byte_cnt_d = '0;
`endif
        end
      end
      StPre: begin
        if (sample_tick) begin
          state_d = StHdr;
          mosi_d  = tx_q[0];
          tx_d    = {1'b0, tx_q[7:1]};
        end
      end
      StHdr: begin
        if (sample_tick) begin
          if (bit_cnt_q == 3'(HDR_BITS - 1)) begin
            state_d   = StData;
            bit_cnt_d = '0;
            mosi_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            mosi_d    = tx_q[0];
            tx_d      = {1'b0, tx_q[7:1]};
          end
        end
      end
      StData: begin
        // Write byte is taken in the first clk of its first bit.
        if (fall_tick && wr_q && (bit_cnt_q == 3'd0)) begin
          wr_ready = 1'b1;
          mosi_d   = wr_data[7];
          tx_d     = {wr_data[6:0], 1'b0};
        end
        if (sample_tick) begin
          rx_d  = rx_next;
          err_d = err_q | ~miso_oe;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            rd_data_d  = rx_next;
            rd_valid_d = 1'b1;
            bit_cnt_d  = '0;
            mosi_d     = 1'b0;
`ifdef SPI_MASTER_CTRL_BURST_EN
            if (byte_cnt_q == len_q) begin
              state_d = StEnd;
            end else begin
              state_d    = StGap;
              byte_cnt_d = byte_cnt_q + 3'd1;
            end
`else
            state_d = StEnd;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            mosi_d    = wr_q & tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
          end
        end
      end
      StGap: begin
        if (sample_tick) begin
          state_d = StData;
        end
      end
      StEnd: begin
        if (end_cnt_q == DivLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          end_cnt_d = end_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_q       <= 1'b0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      end_cnt_q  <= '0;
      mosi_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      end_cnt_q  <= end_cnt_d;
      mosi_q     <= mosi_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef SPI_MASTER_CTRL_BURST_EN
  // Burst length and byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      byte_cnt_q <= '0;
    end else begin
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end
`endif

  assign run       = (state_q == StPre) || (state_q == StHdr) ||
                     (state_q == StData) || (state_q == StGap);
  assign cs        = (state_q == StHdr) || (state_q == StData) || (state_q == StGap);
  assign cmd_ready = (state_q == StIdle);
  // First write bit must appear in the same clk the byte is handed over.
  assign mosi      = wr_ready ? wr_data[7] : mosi_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural slave at ext address 7.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [2:0] cmd_ext;
  logic [2:0] cmd_reg;
  logic [2:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       rsp_err;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       miso_oe;

  int n_cmp = 0;
  int n_bad = 0;

  spi_master_ctrl #(
    .CLK_DIV(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr   (cmd_wr),
    .cmd_ext  (cmd_ext),
    .cmd_reg  (cmd_reg),
    .cmd_len  (cmd_len),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .done     (done),
    .rsp_err  (rsp_err),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe)
  );

  always #5 clk = ~clk;

  // Slave model: PRE pulse (sclk rise with cs low) restarts the frame.
  logic [7:0] sregs [8];
  int         s_bit, s_dbit, s_phase;
  logic       s_wr, s_hit, s_miso;
  logic [2:0] s_ext, s_addr;
  logic [7:0] s_wdata;

  initial begin
    sregs[0] = 8'h12; sregs[1] = 8'h52; sregs[2] = 8'h35; sregs[3] = 8'h35;
    sregs[4] = 8'h36; sregs[5] = 8'h75; sregs[6] = 8'h46; sregs[7] = 8'h35;
    s_bit = 0; s_dbit = 0; s_phase = 0;
    s_wr = 1'b0; s_hit = 1'b0; s_miso = 1'b0;
    s_ext = '0; s_addr = '0; s_wdata = '0;
  end

  always @(posedge sclk) begin
    if (!cs) begin
      s_bit   = 0;
      s_phase = 0;
    end else if (s_phase == 0) begin
      case (s_bit)
        0:       s_wr = mosi;
        1, 2, 3: s_ext[2'(s_bit - 1)] = mosi;
        5, 6, 7: s_addr[2'(s_bit - 5)] = mosi;
        default: ;
      endcase
      s_bit++;
      if (s_bit == 8) begin
        s_phase = 1;
        s_dbit  = 0;
        s_hit   = (s_ext == 3'd7);
      end
    end else if (s_phase == 1) begin
      s_miso  = s_wr ? sregs[s_addr][3'(7 - s_dbit)] : sregs[s_addr][3'(s_dbit)];
      s_wdata = {s_wdata[6:0], mosi};
      s_dbit++;
      if (s_dbit == 8) begin
        if (s_wr && s_hit) sregs[s_addr] = s_wdata;
        s_phase = 2;
      end
    end else begin
      s_addr  = s_addr + 3'd1;
      s_phase = 1;
      s_dbit  = 0;
    end
  end

  assign miso    = s_hit & s_miso;
  assign miso_oe = cs & s_hit & (s_phase != 0);

  // Issues one command and records what the DUT does until done (cycle n = n-th edge after accept).
  task automatic run_cmd(input logic wr, input logic [2:0] ext, input logic [2:0] rg,
                         input logic [2:0] len, input logic [7:0] wb, input int poke_at,
                         output int done_cyc, output int pulses, output int nrd,
                         output int nwr, output int rdv_cyc, output logic err,
                         output logic rdy, output logic [7:0] rb0, output logic [7:0] rb1,
                         output logic [7:0] rb2);
    logic prev;
    int   guard;
    guard = 0;
    while (!cmd_ready && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_ext = ext; cmd_reg = rg; cmd_len = len; wr_data = wb;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    prev = sclk;
    done_cyc = -1; pulses = 0; nrd = 0; nwr = 0; rdv_cyc = -1;
    err = 1'bx; rdy = 1'b0; rb0 = 'x; rb1 = 'x; rb2 = 'x;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk);
      #1;
      if (poke_at > 0 && n == poke_at) begin
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_ext = 3'd7; cmd_reg = 3'd0; cmd_len = 3'd0;
        wr_data = 8'hEE;
      end
      if (poke_at > 0 && n == poke_at + 20) cmd_valid = 1'b0;
      if (sclk && !prev) pulses++;
      prev = sclk;
      if (wr_ready) nwr++;
      if (rd_valid) begin
        if (nrd == 0) begin rb0 = rd_data; rdv_cyc = n; end
        if (nrd == 1) rb1 = rd_data;
        if (nrd == 2) rb2 = rd_data;
        nrd++;
      end
      if (done) begin
        done_cyc = n;
        err      = rsp_err;
        rdy      = cmd_ready;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_ext = '0; cmd_reg = '0;
    cmd_len = '0; wr_data = '0;
    #23;
    n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_cmp++; if (cs !== 1'b0) begin n_bad++; $display("FAIL reset_cs: got %b want 0", cs); end
    n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read;
    int dc, p, nr, nw, rc; logic e, r; logic [7:0] b0, b1, b2;
    run_cmd(1'b0, 3'd7, 3'd2, 3'd0, 8'h00, 0, dc, p, nr, nw, rc, e, r, b0, b1, b2);
    n_cmp++; if (b0 !== 8'h35) begin n_bad++; $display("FAIL read_data: got %h want 35", b0); end
    n_cmp++; if (nr !== 1) begin n_bad++; $display("FAIL read_rd_valid_count: got %0d want 1", nr); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL read_rsp_err: got %b want 0", e); end
    n_cmp++; if (p !== 17) begin n_bad++; $display("FAIL read_sclk_pulses: got %0d want 17", p); end
    n_cmp++; if (dc !== 140) begin n_bad++; $display("FAIL read_done_cycle: got %0d want 140", dc); end
    n_cmp++; if (rc !== 136) begin n_bad++; $display("FAIL read_rd_valid_cycle: got %0d want 136", rc); end
    n_cmp++; if (nw !== 0) begin n_bad++; $display("FAIL read_wr_ready_count: got %0d want 0", nw); end
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL read_ready_with_done: got %b want 1", r); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL read_done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_write_readback;
    int dc, p, nr, nw, rc; logic e, r; logic [7:0] b0, b1, b2;
    run_cmd(1'b1, 3'd7, 3'd5, 3'd0, 8'hA5, 0, dc, p, nr, nw, rc, e, r, b0, b1, b2);
    n_cmp++; if (b0 !== 8'h75) begin n_bad++; $display("FAIL write_old_data: got %h want 75", b0); end
    n_cmp++; if (nw !== 1) begin n_bad++; $display("FAIL write_wr_ready_count: got %0d want 1", nw); end
    n_cmp++; if (sregs[5] !== 8'hA5) begin n_bad++; $display("FAIL write_slave_reg5: got %h want a5", sregs[5]); end
    n_cmp++; if (dc !== 140) begin n_bad++; $display("FAIL write_done_cycle: got %0d want 140", dc); end
    run_cmd(1'b0, 3'd7, 3'd5, 3'd0, 8'h00, 0, dc, p, nr, nw, rc, e, r, b0, b1, b2);
    n_cmp++; if (b0 !== 8'hA5) begin n_bad++; $display("FAIL readback_data: got %h want a5", b0); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL readback_rsp_err: got %b want 0", e); end
  endtask

  task automatic test_burst;
    int dc, p, nr, nw, rc; logic e, r; logic [7:0] b0, b1, b2;
    run_cmd(1'b0, 3'd7, 3'd6, 3'd2, 8'h00, 0, dc, p, nr, nw, rc, e, r, b0, b1, b2);
    n_cmp++; if (b0 !== 8'h46) begin n_bad++; $display("FAIL burst_byte0: got %h want 46", b0); end
`ifdef SPI_MASTER_CTRL_BURST_EN
    n_cmp++; if (nr !== 3) begin n_bad++; $display("FAIL burst_rd_count: got %0d want 3", nr); end
    n_cmp++; if (b1 !== 8'h35) begin n_bad++; $display("FAIL burst_byte1: got %h want 35", b1); end
    n_cmp++; if (b2 !== 8'h12) begin n_bad++; $display("FAIL burst_byte2: got %h want 12", b2); end
    n_cmp++; if (p !== 35) begin n_bad++; $display("FAIL burst_sclk_pulses: got %0d want 35", p); end
    n_cmp++; if (dc !== 284) begin n_bad++; $display("FAIL burst_done_cycle: got %0d want 284", dc); end
`else
    n_cmp++; if (nr !== 1) begin n_bad++; $display("FAIL single_rd_count: got %0d want 1", nr); end
    n_cmp++; if (p !== 17) begin n_bad++; $display("FAIL single_sclk_pulses: got %0d want 17", p); end
    n_cmp++; if (dc !== 140) begin n_bad++; $display("FAIL single_done_cycle: got %0d want 140", dc); end
`endif
  endtask

  task automatic test_unanswered;
    int dc, p, nr, nw, rc; logic e, r; logic [7:0] b0, b1, b2;
    run_cmd(1'b0, 3'd3, 3'd0, 3'd0, 8'h00, 0, dc, p, nr, nw, rc, e, r, b0, b1, b2);
    n_cmp++; if (dc !== 140) begin n_bad++; $display("FAIL noslave_done_cycle: got %0d want 140", dc); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL noslave_rsp_err: got %b want 1", e); end
  endtask

  task automatic test_busy_ignored;
    int dc, p, nr, nw, rc; logic e, r; logic [7:0] b0, b1, b2;
    run_cmd(1'b0, 3'd7, 3'd1, 3'd0, 8'h00, 50, dc, p, nr, nw, rc, e, r, b0, b1, b2);
    n_cmp++; if (b0 !== 8'h52) begin n_bad++; $display("FAIL busy_data: got %h want 52", b0); end
    n_cmp++; if (nw !== 0) begin n_bad++; $display("FAIL busy_wr_ready_count: got %0d want 0", nw); end
    n_cmp++; if (dc !== 140) begin n_bad++; $display("FAIL busy_done_cycle: got %0d want 140", dc); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL busy_rsp_err: got %b want 0", e); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL busy_back_idle: got %b want 1", cmd_ready); end
  endtask

  task automatic test_reset_mid_frame;
    int dc, p, nr, nw, rc; logic e, r; logic [7:0] b0, b1, b2;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_ext = 3'd7; cmd_reg = 3'd3; cmd_len = 3'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    // Header bit 1 (ext[0] = 1), high half.
    n_cmp++; if (cs !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_cs: got %b want 1", cs); end
    n_cmp++; if (sclk !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_sclk: got %b want 1", sclk); end
    n_cmp++; if (mosi !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_mosi: got %b want 1", mosi); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cs !== 1'b0) begin n_bad++; $display("FAIL midrst_cs: got %b want 0", cs); end
    n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL midrst_sclk: got %b want 0", sclk); end
    n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL midrst_mosi: got %b want 0", mosi); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(1'b0, 3'd7, 3'd0, 3'd0, 8'h00, 0, dc, p, nr, nw, rc, e, r, b0, b1, b2);
    n_cmp++; if (b0 !== 8'h12) begin n_bad++; $display("FAIL midrst_next_read: got %h want 12", b0); end
    n_cmp++; if (dc !== 140) begin n_bad++; $display("FAIL midrst_done_cycle: got %0d want 140", dc); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_readback();
    test_burst();
    test_unanswered();
    test_busy_ignored();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
